// File: rtl/crc_pkg.sv
// Shared CRC-8 constants, FSM state encoding and mode values used by the frame
// controller and its byte-step engine.
package crc_pkg;
    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam logic [7:0] CRC8_INIT   = 8'h00;
    localparam logic [7:0] CRC8_XOROUT = 8'h00;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_CRC  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;
endpackage

// File: rtl/crc8_frame_ctrl_if.sv
// Byte stream channel: a transfer happens on a rising edge where valid & ready
// are both high; the master holds valid/data/last stable until that transfer.
interface crc8_frame_ctrl_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc8_step_comb.sv
// One byte of MSB-first, non-reflected CRC-8 update: c ^= d, then eight
// shift/conditional-XOR steps with the generator polynomial.
module crc8_step_comb #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    logic [7:0] c_work;

    always_comb begin
        c_work = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c_work = c_work[7] ? ((c_work << 1) ^ POLY) : (c_work << 1);
        end
        crc_out = c_work;
    end
endmodule

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer around the CRC-8 byte engine: forwards a byte stream through a
// single output register, appends the CRC (GEN) or checks a trailing CRC (CHK).
module crc8_frame_ctrl
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY   = CRC8_POLY,
    parameter logic [7:0] INIT   = CRC8_INIT,
    parameter logic [7:0] XOROUT = CRC8_XOROUT,
    parameter int         LEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    crc8_frame_ctrl_if.slave   s,
    crc8_frame_ctrl_if.master  m,
    output logic               busy,
    output logic               chk_valid,
    output logic               chk_ok,
    output logic [LEN_W-1:0]   frame_len,
    output state_t             state_dbg
);
    state_t             state;
    logic               mode_q;
    logic [7:0]         crc;
    logic [7:0]         crc_prev;
    logic [7:0]         trailer;
    logic [LEN_W-1:0]   len;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_last;

    logic               out_free;
    logic               in_state;
    logic               s_ready_int;
    logic               accept;
    logic               eff_mode;
    logic [7:0]         crc_base;
    logic [7:0]         crc_next;
    logic               final_hs;
    logic [LEN_W-1:0]   len_inc;

    assign out_free    = ~out_valid | m.ready;
    assign in_state    = (state == ST_IDLE) || (state == ST_DATA);
    // Input is also refused in the completion-pulse cycle so frames never overlap.
    assign s_ready_int = in_state & ~chk_valid & out_free;
    assign accept      = s.valid & s_ready_int;
    assign eff_mode    = (state == ST_IDLE) ? mode : mode_q;
    assign crc_base    = (state == ST_IDLE) ? INIT : crc;
    assign final_hs    = out_valid & m.ready & out_last;
    assign len_inc     = (&len) ? len : len + LEN_W'(1);

    assign s.ready   = s_ready_int;
    assign m.valid   = out_valid;
    assign m.data    = out_data;
    assign m.last    = out_last;
    assign state_dbg = state;

    crc8_step_comb #(.POLY(POLY)) u_step (
        .crc_in  (crc_base),
        .data_in (s.data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_GEN;
            crc       <= INIT;
            crc_prev  <= INIT;
            trailer   <= 8'h00;
            len       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            frame_len <= '0;
        end else begin
            chk_valid <= 1'b0;

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= s.data;
                out_last  <= s.last & (eff_mode == MODE_CHK);
            end else if (state == ST_CRC && out_free) begin
                out_valid <= 1'b1;
                out_data  <= crc ^ XOROUT;
                out_last  <= 1'b1;
            end else if (m.ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DATA: begin
                    if (accept) begin
                        crc      <= crc_next;
                        // CRC before the latest byte, so CHK can compare it to the trailer.
                        crc_prev <= crc_base;
                        trailer  <= s.data;
                        if (state == ST_IDLE) begin
                            mode_q <= mode;
                            len    <= LEN_W'(1);
                            busy   <= 1'b1;
                        end else begin
                            len <= len_inc;
                        end
                        if (s.last) begin
                            state <= (eff_mode == MODE_GEN) ? ST_CRC : ST_DONE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_CRC: begin
                    if (out_free) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (final_hs) begin
                        chk_valid <= 1'b1;
                        frame_len <= len;
                        chk_ok    <= (mode_q == MODE_GEN) | ((crc_prev ^ XOROUT) == trailer);
                        busy      <= 1'b0;
                        crc       <= INIT;
                        len       <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
